// File: rtl/cvxif_complex_unit.sv
// CV-X-IF coprocessor responder for the custom-0 complex-number extension.
// Operands are packed {real[31:16], imag[15:0]} in two's complement. Each half
// wraps modulo 2^16. CADD/CCONJ finish in one cycle. CMUL takes four multiply
// steps. Results leave in order through a small result FIFO.
module cvxif_complex_unit #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned RES_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]         issue_rs1_i,
    input  logic [31:0]         issue_rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic [31:0]         result_data_o,
    output logic                result_we_o
);

    localparam int unsigned PtrW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RES_DEPTH + 1);
    localparam logic [6:0]  OpcCustom0 = 7'b0001011;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           step_q, step_d;
    logic [31:0]          acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [31:0]          res_q, res_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic [4:0]           rd_q, rd_d;
    logic [31:0]          a_q, a_d, b_q, b_d;

    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ID_WIDTH-1:0]  fifo_id   [RES_DEPTH];
    logic [4:0]           fifo_rd   [RES_DEPTH];
    logic [31:0]          fifo_data [RES_DEPTH];

    logic                 is_add, is_conj, is_mul, is_hit;
    logic                 handshake, push, pop;
    logic [15:0]          add_re, add_im, conj_im;
    logic [31:0]          quick_res;
    logic signed [15:0]   mul_x, mul_y;
    logic signed [31:0]   prod;
    logic [31:0]          acc_im_sum;
    logic                 unused_instr_bits;

    // Register-source fields are irrelevant to this unit; operands arrive by value.
    assign unused_instr_bits = ^issue_instr_i[24:15];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode the custom-0 complex opcodes.
    always_comb begin
        is_add  = 1'b0;
        is_conj = 1'b0;
        is_mul  = 1'b0;
        if (issue_instr_i[6:0] == OpcCustom0 && issue_instr_i[14:12] == 3'b000) begin
            case (issue_instr_i[31:25])
                7'b0000000: is_add  = 1'b1;
                7'b0000001: is_conj = 1'b1;
                7'b0000010: is_mul  = 1'b1;
                default:    ;
            endcase
        end
    end

    assign is_hit            = is_add | is_conj | is_mul;
    assign issue_ready_o     = (state_q == StIdle) && (count_q < CntW'(RES_DEPTH)) && !rst_i;
    assign handshake         = issue_valid_i && issue_ready_o;
    assign issue_accept_o    = handshake && is_hit;
    assign issue_writeback_o = issue_accept_o;

    // Single-cycle ops are computed straight from the issue operands.
    assign add_re    = issue_rs1_i[31:16] + issue_rs2_i[31:16];
    assign add_im    = issue_rs1_i[15:0] + issue_rs2_i[15:0];
    assign conj_im   = 16'd0 - issue_rs1_i[15:0];
    assign quick_res = is_conj ? {issue_rs1_i[31:16], conj_im} : {add_re, add_im};

    // Pick the operand pair for the current CMUL step.
    always_comb begin
        mul_x = a_q[31:16];
        mul_y = b_q[31:16];
        case (step_q)
            2'd0: begin mul_x = a_q[31:16]; mul_y = b_q[31:16]; end
            2'd1: begin mul_x = a_q[15:0];  mul_y = b_q[15:0];  end
            2'd2: begin mul_x = a_q[31:16]; mul_y = b_q[15:0];  end
            default: begin mul_x = a_q[15:0]; mul_y = b_q[31:16]; end
        endcase
    end

    assign prod       = 32'(mul_x) * 32'(mul_y);
    assign acc_im_sum = acc_im_q + prod;

    // FSM next state, operand latching and multiply accumulation.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        res_d    = res_q;
        id_d     = id_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue_accept_o) begin
                    id_d = issue_id_i;
                    rd_d = issue_instr_i[11:7];
                    a_d  = issue_rs1_i;
                    b_d  = issue_rs2_i;
                    if (is_mul) begin
                        acc_re_d = '0;
                        acc_im_d = '0;
                        step_d   = 2'd0;
                        state_d  = StMul;
                    end else begin
                        res_d   = quick_res;
                        state_d = StDone;
                    end
                end
            end
            StMul: begin
                step_d = step_q + 2'd1;
                case (step_q)
                    2'd0: acc_re_d = acc_re_q + prod;
                    2'd1: acc_re_d = acc_re_q - prod;
                    2'd2: acc_im_d = acc_im_sum;
                    default: begin
                        acc_im_d = acc_im_sum;
                        res_d    = {acc_re_q[15:0], acc_im_sum[15:0]};
                        state_d  = StDone;
                    end
                endcase
            end
            StDone: begin
                // Space was reserved at issue, so the push cannot overflow.
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign result_valid_o = (count_q != '0);
    assign pop            = result_valid_o && result_ready_i;

    // FIFO occupancy and pointer bookkeeping.
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);
    end

    // Control and datapath state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            step_q   <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            res_q    <= '0;
            id_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            res_q    <= res_d;
            id_q     <= id_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    // FIFO storage; contents are only observable while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            fifo_id[wptr_q]   <= id_q;
            fifo_rd[wptr_q]   <= rd_q;
            fifo_data[wptr_q] <= res_q;
        end
    end

    assign result_id_o   = result_valid_o ? fifo_id[rptr_q]   : '0;
    assign result_rd_o   = result_valid_o ? fifo_rd[rptr_q]   : '0;
    assign result_data_o = result_valid_o ? fifo_data[rptr_q] : '0;
    assign result_we_o   = result_valid_o;

endmodule
